// File: rtl/rv_pkg.sv
// Shared core definitions: architectural widths and the writeback queue entry.
package rv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 1 << REG_AW;

    // One queued load response; a dead entry still occupies its slot until popped.
    typedef struct packed {
        logic              live;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    // One-hot register mask used to build the busy vector.
    function automatic logic [NREGS-1:0] rd_onehot(input logic [REG_AW-1:0] rd);
        logic [NREGS-1:0] oh;
        oh     = '0;
        oh[rd] = 1'b1;
        return oh;
    endfunction

    // 32-bit add that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? '1 : sum[31:0];
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular store of load writeback entries with extended pointers.
// Pointers carry one extra wrap bit: full when the wrap bits differ and the
// slot indices match. Live bits of unoccupied slots are kept at zero so the
// per-entry live/rd view can feed the busy vector directly.
module wb_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 4  // power of two, >= 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_push,
    input  wb_entry_t                      i_push_entry,
    input  logic                           i_pop,
    input  logic [DEPTH-1:0]               i_kill,
    output wb_entry_t                      o_head,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [DEPTH-1:0]               o_live,
    output logic [DEPTH-1:0][REG_AW-1:0]   o_rd
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]                   wr_ptr;
    logic [AW:0]                   rd_ptr;
    logic [AW-1:0]                 wr_idx;
    logic [AW-1:0]                 rd_idx;
    logic [DEPTH-1:0]              live_q;
    logic [DEPTH-1:0]              live_d;
    logic [DEPTH-1:0][REG_AW-1:0]  rd_q;
    logic [XLEN-1:0]               data_q [DEPTH];
    logic                          push_ok;
    logic                          pop_ok;

    assign wr_idx  = wr_ptr[AW-1:0];
    assign rd_idx  = rd_ptr[AW-1:0];
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;
    assign o_live  = live_q;
    assign o_rd    = rd_q;

    // Next live bits: kills first, then the popped slot clears, then the pushed slot loads.
    always_comb begin
        // NOTE: combinational blocks use blocking assignments and give every target a
        // default at the top, so later statements see earlier results and no latch forms.
        live_d = live_q & ~i_kill;
        if (pop_ok) begin
            live_d[rd_idx] = 1'b0;
        end
        if (push_ok) begin
            live_d[wr_idx] = i_push_entry.live;
        end
    end

    // Pointers and live bits; reset empties the queue and kills every slot.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            live_q <= '0;
        end else begin
            live_q <= live_d;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Entry payload write on push.
    always_ff @(posedge i_clk) begin
        // NOTE: payload storage is not reset; a slot is only read while its
        // pointers mark it occupied, and the live bit alone decides validity.
        if (push_ok) begin
            rd_q[wr_idx]   <= i_push_entry.rd;
            data_q[wr_idx] <= i_push_entry.data;
        end
    end

    // Head view for the write port.
    always_comb begin
        o_head.live = live_q[rd_idx];
        o_head.rd   = rd_q[rd_idx];
        o_head.data = data_q[rd_idx];
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// ALU results always win the port; load responses queue in order behind them.
// Every ALU result is younger than any queued or same-cycle load, so an ALU
// write kills queued loads to the same register (they would be overwritten).
// Optional build macro WB_STATS_EN adds saturating defer/kill counters.
module wb_arbiter
    import rv_pkg::*;
#(
    parameter int DEPTH = 4  // power of two, >= 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_alu_valid,
    input  logic [REG_AW-1:0] i_alu_rd,
    input  logic [XLEN-1:0]   i_alu_data,
    input  logic              i_ld_valid,
    output logic              o_ld_ready,
    input  logic [REG_AW-1:0] i_ld_rd,
    input  logic [XLEN-1:0]   i_ld_data,
    output logic              o_rd_wen,
    output logic [REG_AW-1:0] o_rd_waddr,
    output logic [XLEN-1:0]   o_rd_wdata,
    output logic [NREGS-1:0]  o_busy,
    output logic              o_ld_empty
`ifdef WB_STATS_EN
    ,
    output logic [31:0]       o_stat_defer,
    output logic [31:0]       o_stat_kill
`endif
);

    wb_entry_t                    head;
    wb_entry_t                    push_entry;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [DEPTH-1:0]             live_v;
    logic [DEPTH-1:0][REG_AW-1:0] rd_v;
    logic [DEPTH-1:0]             kill_v;
    logic                         alu_win;
    logic                         head_live;
    logic                         push;
    logic                         pop;
    logic [NREGS-1:0]             busy;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push       (push),
        .i_push_entry (push_entry),
        .i_pop        (pop),
        .i_kill       (kill_v),
        .o_head       (head),
        .o_full       (fifo_full),
        .o_empty      (fifo_empty),
        .o_live       (live_v),
        .o_rd         (rd_v)
    );

    assign o_ld_ready = !fifo_full;
    assign o_ld_empty = fifo_empty;

    // Port arbitration, head pop and load enqueue decisions.
    always_comb begin
        alu_win    = i_alu_valid && (i_alu_rd != '0);
        head_live  = !fifo_empty && head.live;
        o_rd_wen   = 1'b0;
        o_rd_waddr = '0;
        o_rd_wdata = '0;
        if (alu_win) begin
            o_rd_wen   = 1'b1;
            o_rd_waddr = i_alu_rd;
            o_rd_wdata = i_alu_data;
        end else if (head_live) begin
            o_rd_wen   = 1'b1;
            o_rd_waddr = head.rd;
            o_rd_wdata = head.data;
        end
        // A dead head drains even while the ALU owns the port; a live one waits.
        pop             = !fifo_empty && !(head_live && alu_win);
        // No look-ahead: a full queue refuses even if the head pops this cycle.
        push            = i_ld_valid && !fifo_full;
        push_entry.rd   = i_ld_rd;
        push_entry.data = i_ld_data;
        push_entry.live = (i_ld_rd != '0) && !(alu_win && (i_ld_rd == i_alu_rd));
    end

    // Queued entries overwritten by this cycle's ALU write become dead.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            kill_v[i] = alu_win && live_v[i] && (rd_v[i] == i_alu_rd);
        end
    end

    // Busy vector from registered live entries only; x0 is never busy.
    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_v[i]) begin
                busy = busy | rd_onehot(rd_v[i]);
            end
        end
        o_busy = {busy[NREGS-1:1], 1'b0};
    end

`ifdef WB_STATS_EN
    logic        defer_inc;
    logic [31:0] kill_inc;

    // Per-cycle increments: a blocked live head, and entries killed by ordering.
    always_comb begin
        defer_inc = alu_win && head_live;
        kill_inc  = 32'(push && alu_win && (i_ld_rd != '0) && (i_ld_rd == i_alu_rd));
        for (int i = 0; i < DEPTH; i++) begin
            kill_inc = kill_inc + 32'(kill_v[i]);
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_stat_defer <= '0;
            o_stat_kill  <= '0;
        end else begin
            o_stat_defer <= sat_add32(o_stat_defer, 32'(defer_inc));
            o_stat_kill  <= sat_add32(o_stat_kill, kill_inc);
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed vector table, reset/stat sequences and a
// randomized run against a queue-based reference model.
module tb_wb_arbiter;

    localparam int DEPTH = 4;

    logic        i_clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        o_ld_ready;
    logic        o_rd_wen;
    logic [4:0]  o_rd_waddr;
    logic [31:0] o_rd_wdata;
    logic [31:0] o_busy;
    logic        o_ld_empty;
`ifdef WB_STATS_EN
    logic [31:0] o_stat_defer;
    logic [31:0] o_stat_kill;
`endif

    wb_arbiter #(
        .DEPTH (DEPTH)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (rst),
        .i_alu_valid (alu_valid),
        .i_alu_rd    (alu_rd),
        .i_alu_data  (alu_data),
        .i_ld_valid  (ld_valid),
        .o_ld_ready  (o_ld_ready),
        .i_ld_rd     (ld_rd),
        .i_ld_data   (ld_data),
        .o_rd_wen    (o_rd_wen),
        .o_rd_waddr  (o_rd_waddr),
        .o_rd_wdata  (o_rd_wdata),
        .o_busy      (o_busy),
        .o_ld_empty  (o_ld_empty)
`ifdef WB_STATS_EN
        ,
        .o_stat_defer(o_stat_defer),
        .o_stat_kill (o_stat_kill)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model: an in-order queue of entries ----------------
    typedef struct {
        logic        live;
        logic [4:0]  rd;
        logic [31:0] data;
    } ment_t;

    ment_t       mq[$];
    int unsigned m_defer = 0;
    int unsigned m_kill  = 0;

    task automatic model_check();
        logic        win;
        logic        hl;
        logic        e_wen;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [31:0] e_busy;
        win    = alu_valid && (alu_rd != 0);
        hl     = (mq.size() > 0) && mq[0].live;
        e_wen  = win || hl;
        e_addr = win ? alu_rd : (hl ? mq[0].rd : 5'd0);
        e_data = win ? alu_data : (hl ? mq[0].data : 32'd0);
        e_busy = '0;
        foreach (mq[i]) if (mq[i].live) e_busy[mq[i].rd] = 1'b1;
        check("m_wen", o_rd_wen, e_wen);
        if (e_wen) begin
            check("m_waddr", o_rd_waddr, e_addr);
            check("m_wdata", o_rd_wdata, e_data);
        end
        check("m_busy", o_busy, e_busy);
        check("m_ready", o_ld_ready, mq.size() < DEPTH);
        check("m_empty", o_ld_empty, mq.size() == 0);
`ifdef WB_STATS_EN
        check("m_defer", o_stat_defer, m_defer);
        check("m_kill", o_stat_kill, m_kill);
`endif
    endtask

    task automatic model_update();
        logic  win;
        logic  hl;
        logic  do_pop;
        logic  do_push;
        ment_t e;
        if (rst) begin
            mq.delete();
            m_defer = 0;
            m_kill  = 0;
            return;
        end
        win     = alu_valid && (alu_rd != 0);
        hl      = (mq.size() > 0) && mq[0].live;
        do_pop  = (mq.size() > 0) && !(hl && win);
        do_push = ld_valid && (mq.size() < DEPTH);
        if (win && hl) m_defer++;
        if (win) begin
            foreach (mq[i]) begin
                if (mq[i].live && mq[i].rd == alu_rd) begin
                    mq[i].live = 1'b0;
                    m_kill++;
                end
            end
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            e.rd   = ld_rd;
            e.data = ld_data;
            e.live = (ld_rd != 0);
            if (e.live && win && ld_rd == alu_rd) begin
                e.live = 1'b0;
                m_kill++;
            end
            mq.push_back(e);
        end
    endtask

    // Called with inputs already driven and settled; checks, advances, returns at edge+1.
    task automatic finish_cycle();
        model_check();
        model_update();
        @(posedge i_clk);
        #1;
    endtask

    task automatic cycle(input bit r, input int av, input int ard, input int ad,
                         input int lv, input int lrd, input int ldd);
        rst       = r;
        alu_valid = av[0];
        alu_rd    = 5'(ard);
        alu_data  = 32'(ad);
        ld_valid  = lv[0];
        ld_rd     = 5'(lrd);
        ld_data   = 32'(ldd);
        #1;
        finish_cycle();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldd;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] busy;
        logic        ready;
        logic        empty;
    } vec_t;

    function automatic vec_t mk(input int av, input int ard, input int ad,
                                input int lv, input int lrd, input int ldd,
                                input int wen, input int waddr, input int wdata,
                                input int busy, input int ready, input int empty);
        vec_t v;
        v.av = av[0];   v.ard = 5'(ard);     v.ad = 32'(ad);
        v.lv = lv[0];   v.lrd = 5'(lrd);     v.ldd = 32'(ldd);
        v.wen = wen[0]; v.waddr = 5'(waddr); v.wdata = 32'(wdata);
        v.busy = 32'(busy); v.ready = ready[0]; v.empty = empty[0];
        return v;
    endfunction

    localparam int NV = 36;
    vec_t tbl[NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // ALU only
        tbl[0]  = mk(0, 0, 0,       0, 0, 0,        0, 0, 0,        0,      1, 1);
        tbl[1]  = mk(1, 5, 'h11,    0, 0, 0,        1, 5, 'h11,     0,      1, 1);
        // Load into idle port
        tbl[2]  = mk(0, 0, 0,       1, 7, 'hAB,     0, 0, 0,        0,      1, 1);
        tbl[3]  = mk(0, 0, 0,       0, 0, 0,        1, 7, 'hAB,     'h80,   1, 0);
        tbl[4]  = mk(0, 0, 0,       0, 0, 0,        0, 0, 0,        0,      1, 1);
        // Contention: x3 waits behind three ALU writes
        tbl[5]  = mk(0, 0, 0,       1, 3, 'h33,     0, 0, 0,        0,      1, 1);
        tbl[6]  = mk(1, 9, 'h99,    0, 0, 0,        1, 9, 'h99,     'h8,    1, 0);
        tbl[7]  = mk(1, 9, 'h9A,    0, 0, 0,        1, 9, 'h9A,     'h8,    1, 0);
        tbl[8]  = mk(1, 9, 'h9B,    0, 0, 0,        1, 9, 'h9B,     'h8,    1, 0);
        tbl[9]  = mk(0, 0, 0,       0, 0, 0,        1, 3, 'h33,     'h8,    1, 0);
        tbl[10] = mk(0, 0, 0,       0, 0, 0,        0, 0, 0,        0,      1, 1);
        // WAW kill of two queued x4 loads
        tbl[11] = mk(1, 10, 'hA0,   1, 4, 1,        1, 10, 'hA0,    0,      1, 1);
        tbl[12] = mk(1, 10, 'hA1,   1, 4, 2,        1, 10, 'hA1,    'h10,   1, 0);
        tbl[13] = mk(1, 4, 9,       0, 0, 0,        1, 4, 9,        'h10,   1, 0);
        tbl[14] = mk(0, 0, 0,       0, 0, 0,        0, 0, 0,        0,      1, 0);
        tbl[15] = mk(0, 0, 0,       0, 0, 0,        0, 0, 0,        0,      1, 0);
        tbl[16] = mk(0, 0, 0,       0, 0, 0,        0, 0, 0,        0,      1, 1);
        // Fill to DEPTH with the ALU busy, refuse while full, then drain
        tbl[17] = mk(1, 1, 1,       1, 11, 'hB0,    1, 1, 1,        0,      1, 1);
        tbl[18] = mk(1, 1, 2,       1, 12, 'hB1,    1, 1, 2,        'h800,  1, 0);
        tbl[19] = mk(1, 1, 3,       1, 13, 'hB2,    1, 1, 3,        'h1800, 1, 0);
        tbl[20] = mk(1, 1, 4,       1, 14, 'hB3,    1, 1, 4,        'h3800, 1, 0);
        tbl[21] = mk(1, 1, 5,       1, 15, 'hB4,    1, 1, 5,        'h7800, 0, 0);
        tbl[22] = mk(0, 0, 0,       1, 16, 'hB5,    1, 11, 'hB0,    'h7800, 0, 0);
        tbl[23] = mk(0, 0, 0,       0, 0, 0,        1, 12, 'hB1,    'h7000, 1, 0);
        tbl[24] = mk(0, 0, 0,       0, 0, 0,        1, 13, 'hB2,    'h6000, 1, 0);
        tbl[25] = mk(0, 0, 0,       0, 0, 0,        1, 14, 'hB3,    'h4000, 1, 0);
        tbl[26] = mk(0, 0, 0,       0, 0, 0,        0, 0, 0,        0,      1, 1);
        // Load to x0 is queued dead and drains silently
        tbl[27] = mk(0, 0, 0,       1, 0, 'hC0,     0, 0, 0,        0,      1, 1);
        tbl[28] = mk(0, 0, 0,       0, 0, 0,        0, 0, 0,        0,      1, 0);
        tbl[29] = mk(0, 0, 0,       0, 0, 0,        0, 0, 0,        0,      1, 1);
        // Same-cycle load and ALU to the same register: load enqueued dead
        tbl[30] = mk(1, 6, 'h60,    1, 6, 'h61,     1, 6, 'h60,     0,      1, 1);
        tbl[31] = mk(0, 0, 0,       0, 0, 0,        0, 0, 0,        0,      1, 0);
        tbl[32] = mk(0, 0, 0,       0, 0, 0,        0, 0, 0,        0,      1, 1);
        // ALU to x0 is a no-op: no write, no kill, head still gets the port
        tbl[33] = mk(1, 0, 'hDD,    1, 8, 'h88,     0, 0, 0,        0,      1, 1);
        tbl[34] = mk(1, 0, 'hEE,    0, 0, 0,        1, 8, 'h88,     'h100,  1, 0);
        tbl[35] = mk(0, 0, 0,       0, 0, 0,        0, 0, 0,        0,      1, 1);

        // Reset state
        rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_wen", o_rd_wen, 1'b0);
        check("rst_busy", o_busy, 32'h0);
        check("rst_ready", o_ld_ready, 1'b1);
        check("rst_empty", o_ld_empty, 1'b1);
`ifdef WB_STATS_EN
        check("rst_defer", o_stat_defer, 32'h0);
        check("rst_kill", o_stat_kill, 32'h0);
`endif
        rst = 1'b0;
        mq.delete();

        // Directed table
        for (int i = 0; i < NV; i++) begin
            alu_valid = tbl[i].av;
            alu_rd    = tbl[i].ard;
            alu_data  = tbl[i].ad;
            ld_valid  = tbl[i].lv;
            ld_rd     = tbl[i].lrd;
            ld_data   = tbl[i].ldd;
            #1;
            check($sformatf("v%0d_wen", i), o_rd_wen, tbl[i].wen);
            if (tbl[i].wen) begin
                check($sformatf("v%0d_waddr", i), o_rd_waddr, tbl[i].waddr);
                check($sformatf("v%0d_wdata", i), o_rd_wdata, tbl[i].wdata);
            end
            check($sformatf("v%0d_busy", i), o_busy, tbl[i].busy);
            check($sformatf("v%0d_ready", i), o_ld_ready, tbl[i].ready);
            check($sformatf("v%0d_empty", i), o_ld_empty, tbl[i].empty);
            finish_cycle();
        end

        // Reset with three loads queued discards them
        cycle(0, 1, 1, 'h1, 1, 20, 'hD0);
        cycle(0, 1, 1, 'h2, 1, 21, 'hD1);
        cycle(0, 1, 1, 'h3, 1, 22, 'hD2);
        check("pre_rst_busy", o_busy, 32'h0070_0000);
        cycle(1, 0, 0, 0, 0, 0, 0);
        check("mid_rst_empty", o_ld_empty, 1'b1);
        check("mid_rst_busy", o_busy, 32'h0);
        check("mid_rst_ready", o_ld_ready, 1'b1);
        check("mid_rst_wen", o_rd_wen, 1'b0);

`ifdef WB_STATS_EN
        // Defer count for a load blocked by three ALU writes
        cycle(0, 0, 0, 0, 1, 3, 'h33);
        cycle(0, 1, 9, 'h99, 0, 0, 0);
        cycle(0, 1, 9, 'h9A, 0, 0, 0);
        cycle(0, 1, 9, 'h9B, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("stat_defer3", o_stat_defer, 32'd3);
        // Kill count for two queued loads overwritten by one ALU write
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 10, 'hA0, 1, 4, 1);
        cycle(0, 1, 10, 'hA1, 1, 4, 2);
        cycle(0, 1, 4, 9, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 0);
        check("stat_kill2", o_stat_kill, 32'd2);
`endif

        // Randomized run against the reference model
        for (int n = 0; n < 3000; n++) begin
            int bias;
            bias = (n / 500) % 3;
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 9) < 3 + 2 * bias,
                  $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 9) < 5,
                  $urandom_range(0, 7), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
